pic_to_background_blitter: RTL
==============================

Name: pic_to_background_blitter

Overview:
- Fabric-side copy engine driving the SOPC's two on-chip dual-port memory s2 ports.
- Reads a rectangular sprite from pic_mem (12-bit word address, 16-bit RGB565) and writes it into background_mem (13-bit word address) at (dst_x, dst_y).
- Supports an optional transparent colour key and clips writes to the background bounds.
- The LT24 display path consumes background_mem, so this block is the stage directly upstream of it.

Parameters:
- BG_WIDTH, 128, background row length in words; BG_WIDTH*BG_HEIGHT <= 8192.
- BG_HEIGHT, 64, background row count.
- RD_LAT, 1, pic_mem read latency in clken-enabled cycles; legal values are 1 and 2.

Ports:
- clk  in  1  system clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle command strobe; sampled only in IDLE.
- pic_base  in  12  sprite start word address in pic_mem.
- pic_w  in  8  sprite width in pixels.
- pic_h  in  8  sprite height in pixels.
- dst_x  in  8  destination column.
- dst_y  in  8  destination row.
- key_en  in  1  enables transparency.
- key_color  in  16  transparent colour value.
- hold  in  1  stall request, e.g. while the LCD frame read is active.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle completion pulse.
- pic_address  out  12  to pic_mem_s2_address.
- pic_chipselect  out  1  to pic_mem_s2_chipselect.
- pic_clken  out  1  to pic_mem_s2_clken.
- pic_write  out  1  to pic_mem_s2_write; tied 0.
- pic_writedata  out  16  to pic_mem_s2_writedata; tied 0.
- pic_byteenable  out  2  to pic_mem_s2_byteenable; tied 2'b11.
- pic_readdata  in  16  from pic_mem_s2_readdata.
- bg_address  out  13  to background_mem_s2_address.
- bg_chipselect  out  1  to background_mem_s2_chipselect.
- bg_clken  out  1  to background_mem_s2_clken.
- bg_write  out  1  to background_mem_s2_write.
- bg_writedata  out  16  to background_mem_s2_writedata.
- bg_byteenable  out  2  to background_mem_s2_byteenable; tied 2'b11.

Behaviour:
- Reset: state IDLE. busy=0, done=0, all chipselect/write/clken outputs 0, addresses 0, bg_writedata 0. The pipeline valid bits clear.
- Reset mid-copy aborts immediately. A partially written background is acceptable.
- FSM states: IDLE -> RUN -> DRAIN -> DONE -> IDLE.
- IDLE: when start=1, latch all command inputs and set row=0, col=0.
  - If pic_w==0 or pic_h==0, go to DONE with no memory access.
  - Otherwise go to RUN.
  - start is ignored in every state other than IDLE.
- RUN: each cycle with hold=0 issues one pic read (pic_chipselect=1, pic_clken=1) for pixel (row, col).
  - pic_address = pic_base + row*pic_w + col, computed incrementally and wrapping mod 4096.
  - col increments. At col==pic_w-1, col resets to 0 and row increments.
  - After pixel (pic_h-1, pic_w-1) is issued, go to DRAIN.
- Pipeline: bg address and in-bounds flag travel with each read through an RD_LAT-deep valid/data pipe.
  - bx = dst_x+col and by = dst_y+row, at 9-bit width; no wrap.
  - in_bounds = (bx < BG_WIDTH) && (by < BG_HEIGHT).
  - bg_address = by*BG_WIDTH + bx, truncated to 13 bits; meaningful only when in_bounds.
- Write: when a pipe entry exits valid and hold=0, drive bg_chipselect, bg_clken and bg_write = in_bounds && !(key_en && pic_readdata==key_color), with bg_writedata = pic_readdata.
  - Masked (clipped or keyed) pixels still consume their cycle; only the write strobe is suppressed.
- hold=1: pic_clken=0, bg_chipselect=0, bg_write=0, and pipe and counters freeze. RAM output is held by clken, so no data is lost.
  - hold may toggle on any cycle. Operation resumes the cycle after hold falls.
- DRAIN: stay until the pipe is empty, then go to DONE.
- DONE: done=1 for one cycle, busy=0 in the same cycle, then IDLE. A start arriving in DONE is ignored.
- Timing with no hold, N=pic_w*pic_h, and start sampled at cycle 0:
  - reads in cycles 1..N;
  - writes in cycles 1+RD_LAT..N+RD_LAT;
  - done in cycle N+RD_LAT+1.

Test Plan:
- 4x2 sprite at pic_base=0x010 to (10,5), no key, RD_LAT=1: exactly 8 writes, in cycles 2..9, to bg_address 650..653 and 778..781; done at cycle 10.
- key_en=1, key_color=0xF81F, sprite containing 3 magenta pixels out of 16: exactly 13 bg_write pulses; magenta locations keep their prior contents; done timing identical to the unkeyed case.
- Clipping, 8x8 sprite at (124,60) with BG 128x64: only the 4x4 in-bounds pixels are written, with no address aliasing; done at cycle 64+RD_LAT+1.
- hold pulsed high for 3 cycles mid-row: no read or write strobes while held; the write data sequence is identical to the no-hold run; done is delayed by exactly 3 cycles.
- pic_w=0: done pulses at cycle 1; no chipselect is ever asserted.
- pic_base=0xFFE with a 4-pixel row: pic_address sequence is 0xFFE, 0xFFF, 0x000, 0x001.
- start pulsed while busy: ignored.
- reset_n low mid-RUN: outputs return to reset values asynchronously; a new start afterwards completes correctly.

Source files
------------

// File: rtl/pic_to_background_blitter_if.sv
// Bus bundle for the two on-chip RAM s2 ports that the blitter drives:
// pic_mem (read side) and background_mem (write side).
interface pic_to_background_blitter_if;
  logic [11:0] pic_address;
  logic        pic_chipselect;
  logic        pic_clken;
  logic        pic_write;
  logic [15:0] pic_writedata;
  logic [1:0]  pic_byteenable;
  logic [15:0] pic_readdata;
  logic [12:0] bg_address;
  logic        bg_chipselect;
  logic        bg_clken;
  logic        bg_write;
  logic [15:0] bg_writedata;
  logic [1:0]  bg_byteenable;

  modport master (
    output pic_address, pic_chipselect, pic_clken, pic_write, pic_writedata, pic_byteenable,
    input  pic_readdata,
    output bg_address, bg_chipselect, bg_clken, bg_write, bg_writedata, bg_byteenable
  );
  modport slave (
    input  pic_address, pic_chipselect, pic_clken, pic_write, pic_writedata, pic_byteenable,
    output pic_readdata,
    input  bg_address, bg_chipselect, bg_clken, bg_write, bg_writedata, bg_byteenable
  );
endinterface

// File: rtl/pic_to_background_blitter.sv
// Copies a sprite from pic_mem into background_mem with optional colour key
// and clipping; one pixel per un-held cycle, RD_LAT-deep read pipe.
module pic_to_background_blitter #(
  parameter int BG_WIDTH  = 128,
  parameter int BG_HEIGHT = 64,
  parameter int RD_LAT    = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [11:0] pic_base,
  input  logic [7:0]  pic_w,
  input  logic [7:0]  pic_h,
  input  logic [7:0]  dst_x,
  input  logic [7:0]  dst_y,
  input  logic        key_en,
  input  logic [15:0] key_color,
  input  logic        hold,
  output logic        busy,
  output logic        done,
  pic_to_background_blitter_if.master mem
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  typedef struct packed {
    logic        in_b;
    logic [12:0] addr;
  } pix_t;

  logic [1:0]  state;
  logic [11:0] addr;
  logic [7:0]  w, h, dx, dy, row, col;
  logic        ken;
  logic [15:0] kc;

  logic        issue, mid_busy, drained, wr_slot, keyed;
  logic [8:0]  bx, by;
  pix_t        pix_in;
  logic [RD_LAT:1] vld_pipe;
  pix_t        pipe [RD_LAT:1];

  always_comb begin
    issue       = (state == RUN) && !hold;
    bx          = {1'b0, dx} + {1'b0, col};
    by          = {1'b0, dy} + {1'b0, row};
    pix_in.in_b = (int'(bx) < BG_WIDTH) && (int'(by) < BG_HEIGHT);
    pix_in.addr = 13'(int'(by) * BG_WIDTH + int'(bx));
    mid_busy    = 1'b0;
    for (int i = 1; i < RD_LAT; i++) mid_busy = mid_busy | vld_pipe[i];
    // the exiting entry is consumed this cycle unless held
    drained     = !mid_busy && (!vld_pipe[RD_LAT] || !hold);
    wr_slot     = vld_pipe[RD_LAT] && !hold;
    keyed       = ken && (mem.pic_readdata == kc);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe <= '0;
      for (int i = 1; i <= RD_LAT; i++) pipe[i] <= '0;
    end else if (!hold) begin
      vld_pipe[1] <= issue;
      pipe[1]     <= pix_in;
      for (int i = 2; i <= RD_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        pipe[i]     <= pipe[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      addr  <= '0;
      w     <= '0;
      h     <= '0;
      dx    <= '0;
      dy    <= '0;
      row   <= '0;
      col   <= '0;
      ken   <= 1'b0;
      kc    <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          addr  <= pic_base;
          w     <= pic_w;
          h     <= pic_h;
          dx    <= dst_x;
          dy    <= dst_y;
          ken   <= key_en;
          kc    <= key_color;
          row   <= '0;
          col   <= '0;
          state <= (pic_w == 8'd0 || pic_h == 8'd0) ? DONE : RUN;
        end
        RUN: if (!hold) begin
          // rows are contiguous in pic_mem, so the read address just counts up
          addr <= addr + 12'd1;
          if (col == w - 8'd1) begin
            col <= '0;
            row <= row + 8'd1;
            if (row == h - 8'd1) state <= DRAIN;
          end else begin
            col <= col + 8'd1;
          end
        end
        DRAIN: if (drained) state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == RUN) || (state == DRAIN);
  assign done = (state == DONE);

  assign mem.pic_address    = addr;
  assign mem.pic_chipselect = issue;
  // clken keeps advancing the RAM output stage while the pipe drains
  assign mem.pic_clken      = busy && !hold;
  assign mem.pic_write      = 1'b0;
  assign mem.pic_writedata  = '0;
  assign mem.pic_byteenable = 2'b11;

  assign mem.bg_address     = pipe[RD_LAT].addr;
  assign mem.bg_chipselect  = wr_slot;
  assign mem.bg_clken       = wr_slot;
  assign mem.bg_write       = wr_slot && pipe[RD_LAT].in_b && !keyed;
  assign mem.bg_writedata   = wr_slot ? mem.pic_readdata : 16'd0;
  assign mem.bg_byteenable  = 2'b11;
endmodule
